// File: rtl/mem_wait_responder.sv
// ============================================================================
//  Module   : mem_wait_responder
//  Purpose  : Word-addressed RAM responder for CPU load/store/fetch requests.
//             Accepts one request at a time and answers it after a fixed,
//             programmable number of wait states with a one-cycle ready pulse.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wait_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int READ_LAT    = 3,
  parameter int WRITE_LAT   = 2
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_req,
  input  logic        i_wr,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_err,
  output logic        o_busy
);

  localparam int c_MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
  localparam int c_IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               r_state;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_wr;
  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic                 r_ready;
  logic                 r_err;
  logic                 r_busy;
  logic [31:0]          r_rdata;
  logic [31:0]          r_mem [DEPTH_WORDS];

  logic                 w_misalign;
  logic                 w_out_of_range;
  logic                 w_bad;
  logic [c_IDX_W-1:0]   w_idx;
  logic                 w_commit;

  // Address legality is judged on the latched request, never on live inputs.
  assign w_misalign     = |r_addr[1:0];
  assign w_out_of_range = (r_addr[31:2] >= 30'(DEPTH_WORDS));
  assign w_bad          = w_misalign | w_out_of_range;
  assign w_idx          = r_addr[c_IDX_W+1:2];

  // The edge that moves WAIT -> RESP is the one that performs the access.
  // The counter holds the remaining wait edges, so the access lands exactly
  // LAT edges after acceptance. Reset on that same edge cancels the access.
  assign w_commit = (r_state == S_WAIT) && (r_cnt == '0) && !i_reset;

  // RAM write port: only a legal, uncancelled write reaches storage.
  always_ff @(posedge i_clock) begin
    if (w_commit && r_wr && !w_bad) begin
      r_mem[w_idx] <= r_wdata;
    end
  end

  // Request FSM with registered response outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          if (i_req) begin
            r_wr    <= i_wr;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
            r_cnt   <= i_wr ? c_CNT_W'(WRITE_LAT - 1) : c_CNT_W'(READ_LAT - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_ready <= 1'b1;
            r_err   <= w_bad;
            r_rdata <= (!r_wr && !w_bad) ? r_mem[w_idx] : 32'd0;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - c_CNT_W'(1);
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b0;
          r_err   <= 1'b0;
          r_rdata <= '0;
        end
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_err   = r_err;
  assign o_busy  = r_busy;
  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_wait_responder.sv
// ============================================================================
//  Module   : tb_mem_wait_responder
//  Purpose  : Directed self-checking bench for mem_wait_responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wait_responder;

  localparam int c_RLAT = 3;
  localparam int c_WLAT = 2;

  logic        clk;
  logic        rst;
  logic        req;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;
  logic        busy;

  int n_assert;
  int n_fail;

  mem_wait_responder #(
    .DEPTH_WORDS (256),
    .READ_LAT    (c_RLAT),
    .WRITE_LAT   (c_WLAT)
  ) u_dut (
    .i_clock (clk),
    .i_reset (rst),
    .i_req   (req),
    .i_wr    (wr),
    .i_addr  (addr),
    .i_wdata (wdata),
    .o_ready (ready),
    .o_rdata (rdata),
    .o_err   (err),
    .o_busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and settle 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a request and check the full response timeline. When poke is set,
  // a competing write to 0x20 is driven through every wait and ready cycle.
  task automatic access(input string tag, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input int lat,
                        input logic [31:0] exp_rd, input logic exp_err,
                        input logic poke);
    req = 1'b1; wr = w; addr = a; wdata = d;
    step();
    if (poke) begin
      req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hBADBAD00;
    end else begin
      req = 1'b0;
    end
    chk({tag, ".busy_after_accept"}, {31'd0, busy}, 32'd1);
    chk({tag, ".ready_early"}, {31'd0, ready}, 32'd0);
    for (int i = 1; i < lat; i++) begin
      step();
      chk({tag, ".ready_wait"}, {31'd0, ready}, 32'd0);
    end
    step();
    chk({tag, ".ready"}, {31'd0, ready}, 32'd1);
    chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
    chk({tag, ".rdata"}, rdata, exp_rd);
    chk({tag, ".busy_resp"}, {31'd0, busy}, 32'd1);
    step();
    req = 1'b0;
    chk({tag, ".ready_drop"}, {31'd0, ready}, 32'd0);
    chk({tag, ".rdata_drop"}, rdata, 32'd0);
    chk({tag, ".err_drop"}, {31'd0, err}, 32'd0);
    chk({tag, ".busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    step();
    step();
    rst = 1'b0;
    chk("reset.ready", {31'd0, ready}, 32'd0);
    chk("reset.err",   {31'd0, err},   32'd0);
    chk("reset.busy",  {31'd0, busy},  32'd0);
    chk("reset.rdata", rdata, 32'd0);
    step();

    // T1 / T2: write then read back.
    access("T1_wr10", 1'b1, 32'h10, 32'hDEADBEEF, c_WLAT, 32'd0, 1'b0, 1'b0);
    access("T2_rd10", 1'b0, 32'h10, 32'h0, c_RLAT, 32'hDEADBEEF, 1'b0, 1'b0);

    // T3: misaligned write is rejected and leaves storage alone.
    access("T3_wr13", 1'b1, 32'h13, 32'h1234, c_WLAT, 32'd0, 1'b1, 1'b0);
    access("T3_rd10", 1'b0, 32'h10, 32'h0, c_RLAT, 32'hDEADBEEF, 1'b0, 1'b0);

    // T4: out-of-range read, plus the last valid word as a boundary.
    access("T4_rd400", 1'b0, 32'h400, 32'h0, c_RLAT, 32'd0, 1'b1, 1'b0);
    access("T4_wr3FC", 1'b1, 32'h3FC, 32'hA5A5_0FF0, c_WLAT, 32'd0, 1'b0, 1'b0);
    access("T4_rd3FC", 1'b0, 32'h3FC, 32'h0, c_RLAT, 32'hA5A5_0FF0, 1'b0, 1'b0);

    // Known prior value at 0x20 for T5/T6.
    access("pre_wr20", 1'b1, 32'h20, 32'h11112222, c_WLAT, 32'd0, 1'b0, 1'b0);

    // T5: competing requests during WAIT and RESP are ignored.
    access("T5_wr24", 1'b1, 32'h24, 32'h5555AAAA, c_WLAT, 32'd0, 1'b0, 1'b1);
    step();
    chk("T5.no_second_busy",  {31'd0, busy},  32'd0);
    chk("T5.no_second_ready", {31'd0, ready}, 32'd0);
    access("T5_rd24", 1'b0, 32'h24, 32'h0, c_RLAT, 32'h5555AAAA, 1'b0, 1'b0);
    access("T5_rd20", 1'b0, 32'h20, 32'h0, c_RLAT, 32'h11112222, 1'b0, 1'b0);

    // T6: reset one edge after accepting a write cancels it.
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'hCAFEF00D;
    step();
    req = 1'b0;
    chk("T6.busy_after_accept", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("T6.ready", {31'd0, ready}, 32'd0);
    chk("T6.busy",  {31'd0, busy},  32'd0);
    chk("T6.err",   {31'd0, err},   32'd0);
    chk("T6.rdata", rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("T6.no_ready", {31'd0, ready}, 32'd0);
    end
    access("T6_rd20", 1'b0, 32'h20, 32'h0, c_RLAT, 32'h11112222, 1'b0, 1'b0);

    // Reset landing on the access edge of a write: no commit, no ready.
    req = 1'b1; wr = 1'b1; addr = 32'h10; wdata = 32'h0BAD0BAD;
    step();
    req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("T7.ready", {31'd0, ready}, 32'd0);
    chk("T7.busy",  {31'd0, busy},  32'd0);
    step();
    access("T7_rd10", 1'b0, 32'h10, 32'h0, c_RLAT, 32'hDEADBEEF, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
